// File: rtl/axi_slave_ram.sv
// AXI4 INCR-burst slave RAM of MEM_DEPTH 64-bit words; independent read and write channels; optional stall via AXI_SLV_STALL_EN.
// Latency: write beat stored on its W handshake, B the cycle after wlast; first R beat one cycle after AR, then one beat per cycle.
// Backpressure: R and B held stable until rready/bready; AXI_SLV_STALL_EN drops awready/wready/arready every 4th cycle.
module axi_slave_ram #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [29:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic stall;
`ifdef AXI_SLV_STALL_EN
    logic [1:0] stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else        stall_cnt <= stall_cnt + 2'd1;
    end
    assign stall = (stall_cnt == 2'd3);
`else
    assign stall = 1'b0;
`endif

    // Byte-offset and out-of-range address bits are deliberately dropped (modulo wrap).
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr[29:AW+3], s_axi_awaddr[2:0],
                           s_axi_araddr[29:AW+3], s_axi_araddr[2:0]};

    logic [63:0] mem [MEM_DEPTH];

    w_state_t       w_state, w_next;
    logic [AW-1:0]  w_addr;
    logic [7:0]     w_len, w_cnt;
    logic           w_over;
    logic [1:0]     bresp_q;
    logic           aw_hs, w_hs, b_hs;

    assign s_axi_awready = (w_state == W_IDLE) && !stall;
    assign s_axi_wready  = (w_state == W_DATA) && !stall;
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bresp   = bresp_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && s_axi_wlast) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // w_over remembers a beat past awlen without wlast, so a late wlast still gets SLVERR after counter wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_over  <= 1'b0;
            bresp_q <= 2'b00;
        end else if (aw_hs) begin
            w_addr <= s_axi_awaddr[AW+2:3];
            w_len  <= s_axi_awlen;
            w_cnt  <= '0;
            w_over <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_addr + AW'(1);
            w_cnt  <= w_cnt + 8'd1;
            if (!s_axi_wlast && (w_cnt == w_len))
                w_over <= 1'b1;
            if (s_axi_wlast)
                bresp_q <= ((w_cnt == w_len) && !w_over) ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b])
                    mem[w_addr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    r_state_t       r_state, r_next;
    logic [AW-1:0]  r_addr;
    logic [7:0]     r_len, r_cnt;
    logic [63:0]    rdata_q;
    logic           rlast_q;
    logic           ar_hs, r_hs;
    logic [AW-1:0]  ar_idx;

    assign ar_idx        = s_axi_araddr[AW+2:3];
    assign s_axi_arready = (r_state == R_IDLE) && !stall;
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = 2'b00;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // r_addr always points at the word to load on the next accepted beat, so beats stream without bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
        end else if (ar_hs) begin
            rdata_q <= mem[ar_idx];
            r_addr  <= ar_idx + AW'(1);
            r_len   <= s_axi_arlen;
            r_cnt   <= '0;
            rlast_q <= (s_axi_arlen == 8'd0);
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                rdata_q <= mem[r_addr];
                r_addr  <= r_addr + AW'(1);
                r_cnt   <= r_cnt + 8'd1;
                rlast_q <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Bench for axi_slave_ram: vector table, randomized bursts against a word-array model, and hand-written corner sequences.
module tb_axi_slave_ram;
    localparam int DEPTH  = 1024;
    localparam int BUDGET = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [29:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_arvalid, s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    axi_slave_ram #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation did not finish");
    end

    int n_checks = 0;
    int n_errors = 0;
    int w_stall_cnt = 0;

    logic [63:0] ref_mem [DEPTH];
    logic [63:0] wbuf_d  [256];
    logic [7:0]  wbuf_s  [256];
    logic [63:0] rbuf    [256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    function automatic int word_of(input logic [29:0] addr);
        return int'(addr[12:3]);
    endfunction

    // Model: each beat lands in the next word modulo DEPTH, only strobed bytes change.
    function automatic void model_write(input logic [29:0] addr, input int nbeats);
        int idx;
        for (int i = 0; i < nbeats; i++) begin
            idx = (word_of(addr) + i) % DEPTH;
            for (int b = 0; b < 8; b++)
                if (wbuf_s[i][b]) ref_mem[idx][8*b +: 8] = wbuf_d[i][8*b +: 8];
        end
    endfunction

    task automatic do_write(input logic [29:0] addr, input int len, input int nbeats,
                            output logic [1:0] bresp_o);
        int t;
        bresp_o = 2'b11;
        @(negedge clk);
        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) begin timeout_fail("aw"); s_axi_awvalid = 1'b0; return; end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            s_axi_wdata = wbuf_d[i]; s_axi_wstrb = wbuf_s[i];
            s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < BUDGET) begin @(negedge clk); t++; w_stall_cnt++; end
            if (t >= BUDGET) begin timeout_fail("w"); s_axi_wvalid = 1'b0; return; end
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
        t = 0;
        while (!s_axi_bvalid && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) begin timeout_fail("b"); s_axi_bready = 1'b0; return; end
        bresp_o = s_axi_bresp;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("b_done", s_axi_bvalid, 0);
        model_write(addr, nbeats);
    endtask

    task automatic do_read(input logic [29:0] addr, input int len, input bit rnd, input int hold_at);
        int t, i, idx;
        bit held;
        @(negedge clk);
        s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) begin timeout_fail("ar"); s_axi_arvalid = 1'b0; return; end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("r_first_vld", s_axi_rvalid, 1);
        i = 0; t = 0; held = 0;
        while (i <= len && t < BUDGET) begin
            idx = (word_of(addr) + i) % DEPTH;
            if (i == hold_at && !held) begin
                s_axi_rready = 1'b0;
                held = 1;
                repeat (5) begin
                    @(negedge clk);
                    check("hold_vld", s_axi_rvalid, 1);
                    check("hold_dat", s_axi_rdata, ref_mem[idx]);
                end
            end
            s_axi_rready = rnd ? 1'($urandom % 2) : 1'b1;
            if (s_axi_rready && s_axi_rvalid) begin
                check("r_dat", s_axi_rdata, ref_mem[idx]);
                check("r_last", s_axi_rlast, 64'(i == len));
                check("r_resp", s_axi_rresp, 0);
                rbuf[i] = s_axi_rdata;
                i++;
            end
            @(negedge clk);
            t++;
        end
        s_axi_rready = 1'b0;
        if (i <= len) timeout_fail("r_beats");
        else check("r_done", s_axi_rvalid, 0);
    endtask

    typedef struct {
        logic [29:0] addr;
        int          len;
        int          nbeats;
        logic [7:0]  strb;
        logic [63:0] seed;
        logic [1:0]  exp_bresp;
        bit          chk;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
    } vec_t;

    vec_t vecs [8];
    logic [1:0]  br;
    logic [29:0] a;
    logic [63:0] old_v, new_v;
    int t;

    initial begin
        vecs[0] = '{30'h0,         3, 4, 8'hFF, 64'h11,  2'b00, 1, 64'h11, 64'h44};
        vecs[1] = '{30'h40,        0, 1, 8'hFF, '1,      2'b00, 1, '1, '1};
        vecs[2] = '{30'h40,        0, 1, 8'h0F, 64'h0,   2'b00, 1,
                    64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000};
        vecs[3] = '{30'h100,       3, 2, 8'hFF, 64'h1234, 2'b10, 1, 64'h1234, 64'h2468};
        vecs[4] = '{30'h1FF8,      1, 2, 8'hFF, 64'hABCD, 2'b00, 1, 64'hABCD, 64'h1579A};
        vecs[5] = '{30'h200,       1, 4, 8'hFF, 64'h77,   2'b10, 1, 64'h77, 64'h1DC};
        vecs[6] = '{30'h300,       0, 1, 8'hA5, 64'h5A5A, 2'b00, 0, 64'h0, 64'h0};
        vecs[7] = '{30'h2000_0013, 2, 3, 8'hFF, 64'h5,    2'b00, 1, 64'h5, 64'hF};

        rst_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_bresp",  s_axi_bresp, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rlast",  s_axi_rlast, 0);
        check("rst_rdata",  s_axi_rdata, 0);
        rst_n = 1'b1;
        #1;
        check("rst_awready", s_axi_awready, 1);
        check("rst_arready", s_axi_arready, 1);
        check("rst_wready",  s_axi_wready, 0);

        // Fill the whole RAM so every later read has a known expected word.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) begin
                wbuf_d[i] = {$urandom, $urandom};
                wbuf_s[i] = 8'hFF;
            end
            do_write(30'(k * 256 * 8), 255, 256, br);
            check("fill_bresp", br, 2'b00);
        end

        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].nbeats; i++) begin
                wbuf_d[i] = vecs[v].seed * 64'(i + 1);
                wbuf_s[i] = vecs[v].strb;
            end
            do_write(vecs[v].addr, vecs[v].len, vecs[v].nbeats, br);
            check("vec_bresp", br, vecs[v].exp_bresp);
            do_read(vecs[v].addr, vecs[v].nbeats - 1, 0, -1);
            if (vecs[v].chk) begin
                check("vec_first", rbuf[0], vecs[v].exp_first);
                check("vec_last",  rbuf[vecs[v].nbeats - 1], vecs[v].exp_last);
            end
        end
        do_read(30'h0, 0, 0, -1);

        for (int n = 0; n < 30; n++) begin
            int len;
            len = int'($urandom_range(0, 15));
            a = 30'($urandom_range(0, DEPTH - 1)) << 3;
            for (int i = 0; i <= len; i++) begin
                wbuf_d[i] = {$urandom, $urandom};
                wbuf_s[i] = 8'($urandom);
            end
            do_write(a, len, len + 1, br);
            check("rand_bresp", br, 2'b00);
            a = (30'($urandom_range(0, DEPTH - 1)) << 3) | 30'($urandom_range(0, 7));
            do_read(a, int'($urandom_range(0, 15)), 1, -1);
        end

        do_read(30'h0, 7, 0, 3);

        // 8-beat burst with wvalid held: stalls appear only when the stall option is built in.
        for (int i = 0; i < 8; i++) begin
            wbuf_d[i] = {$urandom, $urandom};
            wbuf_s[i] = 8'hFF;
        end
        w_stall_cnt = 0;
        do_write(30'h800, 7, 8, br);
        check("burst8_bresp", br, 2'b00);
`ifdef AXI_SLV_STALL_EN
        check("burst8_stalls", 64'((w_stall_cnt >= 2) && (w_stall_cnt <= 3)), 1);
`else
        check("burst8_stalls", w_stall_cnt, 0);
`endif
        do_read(30'h800, 7, 1, -1);

        // Write and read of the same word in one cycle: read must see the old contents.
        old_v = ref_mem[60];
        new_v = ~old_v;
        @(negedge clk);
        s_axi_awaddr = 30'h1E0; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) timeout_fail("rw_aw");
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wdata = new_v; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 30'h1E0; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        t = 0;
        while (!(s_axi_wready && s_axi_arready) && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) timeout_fail("rw_both");
        @(negedge clk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        check("rw_rvalid", s_axi_rvalid, 1);
        check("rw_old",    s_axi_rdata, old_v);
        check("rw_rlast",  s_axi_rlast, 1);
        check("rw_bvalid", s_axi_bvalid, 1);
        check("rw_bresp",  s_axi_bresp, 0);
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        check("rw_r_done", s_axi_rvalid, 0);
        check("rw_b_done", s_axi_bvalid, 0);
        ref_mem[60] = new_v;
        do_read(30'h1E0, 0, 0, -1);

        // Reset in the middle of a read burst: burst dropped, memory kept.
        @(negedge clk);
        s_axi_araddr = 30'h0; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < BUDGET) begin @(negedge clk); t++; end
        if (t >= BUDGET) timeout_fail("rst_ar");
        @(negedge clk);
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        repeat (2) @(negedge clk);
        s_axi_rready = 1'b0;
        check("mid_rvalid_pre", s_axi_rvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rvalid", s_axi_rvalid, 0);
        check("mid_arready", s_axi_arready, 1);
        check("mid_rdata", s_axi_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_awready", s_axi_awready, 1);
        check("post_arready", s_axi_arready, 1);
        check("post_wready", s_axi_wready, 0);
        check("post_bvalid", s_axi_bvalid, 0);
        check("post_rvalid", s_axi_rvalid, 0);
        do_read(30'h0, 7, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
